// File: rtl/staged_cpu.sv
// rtl/staged_cpu.sv - two-stage (fetch/execute) accumulator-style CPU with register file
//
// Ports:
//   clock          sole clock, all state updates on rising edge
//   isResetN       asynchronous active-low reset
//   switch         external value loaded by LOADSWITCH
//   imemReq        instruction fetch request (high in FETCH only)
//   imemAddr       fetch address, always equal to pc
//   imemValid      fetch data valid, accepted while imemReq=1
//   imemData       fetched instruction: opcode|regOut|reg1|reg2|value
//   pc             current program counter
//   register1Value value of register reg1 of the latched instruction
//   halted         set once HALT executes, cleared only by reset
//   zeroFlag       result==0 of the last ALU instruction
//   carryFlag      carry/borrow/shifted-out bit of the last ALU instruction
//   retired        saturating count of executed instructions
module staged_cpu #(
  parameter int REGISTER_WIDTH      = 8,
  parameter int NUMBER_OF_REGISTERS = 8,
  parameter int PC_WIDTH            = 8,
  localparam int RA                 = $clog2(NUMBER_OF_REGISTERS),
  localparam int INSTRUCTION_WIDTH  = 6 + 3*RA + REGISTER_WIDTH
) (
  input  logic                         clock,
  input  logic                         isResetN,
  input  logic [REGISTER_WIDTH-1:0]    switch,
  output logic                         imemReq,
  output logic [PC_WIDTH-1:0]          imemAddr,
  input  logic                         imemValid,
  input  logic [INSTRUCTION_WIDTH-1:0] imemData,
  output logic [PC_WIDTH-1:0]          pc,
  output logic [REGISTER_WIDTH-1:0]    register1Value,
  output logic                         halted,
  output logic                         zeroFlag,
  output logic                         carryFlag,
  output logic [15:0]                  retired
);

  localparam logic [5:0] OP_ADD        = 6'h01;
  localparam logic [5:0] OP_SUB        = 6'h02;
  localparam logic [5:0] OP_INC        = 6'h03;
  localparam logic [5:0] OP_DEC        = 6'h04;
  localparam logic [5:0] OP_LSHIFT     = 6'h05;
  localparam logic [5:0] OP_RSHIFT     = 6'h06;
  localparam logic [5:0] OP_LOAD       = 6'h07;
  localparam logic [5:0] OP_LOADSWITCH = 6'h08;
  localparam logic [5:0] OP_JUMP       = 6'h20;
  localparam logic [5:0] OP_JUMPZ      = 6'h21;
  localparam logic [5:0] OP_HALT       = 6'h3F;

  localparam logic [REGISTER_WIDTH:0] ONE_WIDE = {{REGISTER_WIDTH{1'b0}}, 1'b1};
  localparam logic [PC_WIDTH-1:0]     PC_ONE   = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {FETCH, EXECUTE, HALT} state_t;

  state_t                         state;
  logic [INSTRUCTION_WIDTH-1:0]   instr;
  logic [REGISTER_WIDTH-1:0]      regs [NUMBER_OF_REGISTERS];

  logic [5:0]                     opcode;
  logic [RA-1:0]                  regOut;
  logic [RA-1:0]                  reg1;
  logic [RA-1:0]                  reg2;
  logic [REGISTER_WIDTH-1:0]      value;
  logic [REGISTER_WIDTH-1:0]      op1;
  logic [REGISTER_WIDTH-1:0]      op2;
  logic [REGISTER_WIDTH-1:0]      aluResult;
  logic                           aluCarry;
  logic                           aluWrite;
  logic [PC_WIDTH-1:0]            jumpTarget;
  logic [PC_WIDTH-1:0]            pcInc;

  assign opcode = instr[INSTRUCTION_WIDTH-1 -: 6];
  assign regOut = instr[INSTRUCTION_WIDTH-7 -: RA];
  assign reg1   = instr[INSTRUCTION_WIDTH-7-RA -: RA];
  assign reg2   = instr[REGISTER_WIDTH+RA-1 -: RA];
  assign value  = instr[REGISTER_WIDTH-1:0];

  // Register 0 is hard-wired to zero on the read side, so writes to it can
  // simply be suppressed without needing to keep the storage cleared.
  assign op1 = (reg1 == '0) ? '0 : regs[reg1];
  assign op2 = (reg2 == '0) ? '0 : regs[reg2];

  assign register1Value = op1;
  assign imemAddr       = pc;
  assign pcInc          = pc + PC_ONE;

  generate
    if (PC_WIDTH <= REGISTER_WIDTH) begin : g_jump_trunc
      assign jumpTarget = value[PC_WIDTH-1:0];
    end else begin : g_jump_ext
      assign jumpTarget = {{(PC_WIDTH-REGISTER_WIDTH){1'b0}}, value};
    end
  endgenerate

  // Arithmetic is done one bit wider so the top bit is the carry or, for
  // subtraction, the borrow.
  always_comb begin
    aluResult = '0;
    aluCarry  = 1'b0;
    aluWrite  = 1'b1;
    case (opcode)
      OP_ADD:        {aluCarry, aluResult} = {1'b0, op1} + {1'b0, op2};
      OP_SUB:        {aluCarry, aluResult} = {1'b0, op1} - {1'b0, op2};
      OP_INC:        {aluCarry, aluResult} = {1'b0, op1} + ONE_WIDE;
      OP_DEC:        {aluCarry, aluResult} = {1'b0, op1} - ONE_WIDE;
      OP_LSHIFT: begin
        aluCarry  = op1[REGISTER_WIDTH-1];
        aluResult = {op1[REGISTER_WIDTH-2:0], 1'b0};
      end
      OP_RSHIFT: begin
        aluCarry  = op1[0];
        aluResult = {1'b0, op1[REGISTER_WIDTH-1:1]};
      end
      OP_LOAD:       aluResult = value;
      OP_LOADSWITCH: aluResult = switch;
      default:       aluWrite  = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      state     <= FETCH;
      pc        <= '0;
      instr     <= '0;
      zeroFlag  <= 1'b0;
      carryFlag <= 1'b0;
      retired   <= '0;
      halted    <= 1'b0;
      imemReq   <= 1'b1;
      for (int i = 0; i < NUMBER_OF_REGISTERS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        FETCH: begin
          if (imemValid) begin
            instr   <= imemData;
            state   <= EXECUTE;
            imemReq <= 1'b0;
          end
        end
        EXECUTE: begin
          if (retired != 16'hFFFF) begin
            retired <= retired + 16'd1;
          end
          if (aluWrite) begin
            if (regOut != '0) begin
              regs[regOut] <= aluResult;
            end
            zeroFlag  <= (aluResult == '0);
            carryFlag <= aluCarry;
          end
          case (opcode)
            OP_JUMP:  pc <= jumpTarget;
            OP_JUMPZ: pc <= (op1 == '0) ? jumpTarget : pcInc;
            OP_HALT:  pc <= pc;
            default:  pc <= pcInc;
          endcase
          if (opcode == OP_HALT) begin
            state   <= HALT;
            halted  <= 1'b1;
            imemReq <= 1'b0;
          end else begin
            state   <= FETCH;
            imemReq <= 1'b1;
          end
        end
        HALT: begin
          imemReq <= 1'b0;
        end
        default: begin
          state   <= FETCH;
          imemReq <= 1'b1;
        end
      endcase
    end
  end

endmodule
